alu_share_arbiter: RTL

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 20 ++
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and arbiter state encoding.
// Used by both the external ALU and the arbiter.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin choice: a lone request wins outright,
// and on a tie the requester that was not granted last wins.
module rr_pick2 (
    input  logic Req0,
    input  logic Req1,
    input  logic LastId,
    output logic valid,
    output logic id
);

    always_comb begin
        valid = Req0 | Req1;
        if (Req0 && Req1) begin
            id = ~LastId;
        end else begin
            id = Req1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one external ALU: grant, execute for one
// cycle, then hold the response until the consumer accepts it.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [DATA_W-1:0] A0,
    input  logic [DATA_W-1:0] B0,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] B1,
    input  logic [3:0]        Ctrl0,
    input  logic [3:0]        Ctrl1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic [3:0]        ALUCtrl,
    input  logic [DATA_W-1:0] BusW,
    input  logic              Zero,
    output logic              RespValid,
    input  logic              RespReady,
    output logic              RespId,
    output logic [DATA_W-1:0] RespW,
    output logic              RespZero,
    output logic              RespErr
);

    arb_state_t        state_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [3:0]        ctrl_reg;
    logic              id_reg;
    logic              last_id_reg;
    logic              gnt0_reg;
    logic              gnt1_reg;
    logic              resp_valid_reg;
    logic              resp_id_reg;
    logic [DATA_W-1:0] resp_w_reg;
    logic              resp_zero_reg;
    logic              resp_err_reg;

    logic pick_valid;
    logic pick_id;

    rr_pick2 u_pick (
        .Req0   (Req0),
        .Req1   (Req1),
        .LastId (last_id_reg),
        .valid  (pick_valid),
        .id     (pick_id)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            ctrl_reg       <= '0;
            id_reg         <= 1'b0;
            last_id_reg    <= 1'b1;
            gnt0_reg       <= 1'b0;
            gnt1_reg       <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= 1'b0;
            resp_w_reg     <= '0;
            resp_zero_reg  <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            gnt0_reg <= 1'b0;
            gnt1_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Requests are only looked at here; the grant pulse covers the EXEC cycle.
                    if (pick_valid) begin
                        a_reg       <= pick_id ? A1 : A0;
                        b_reg       <= pick_id ? B1 : B0;
                        ctrl_reg    <= pick_id ? Ctrl1 : Ctrl0;
                        id_reg      <= pick_id;
                        last_id_reg <= pick_id;
                        gnt0_reg    <= ~pick_id;
                        gnt1_reg    <= pick_id;
                        state_reg   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_w_reg     <= BusW;
                    resp_zero_reg  <= Zero;
                    resp_err_reg   <= ~is_legal_op(ctrl_reg);
                    resp_id_reg    <= id_reg;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (RespReady) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // The shared ALU sees quiet zero inputs except while this block owns it.
    assign BusA    = (state_reg == ST_EXEC) ? a_reg    : '0;
    assign BusB    = (state_reg == ST_EXEC) ? b_reg    : '0;
    assign ALUCtrl = (state_reg == ST_EXEC) ? ctrl_reg : 4'b0000;

    assign Gnt0      = gnt0_reg;
    assign Gnt1      = gnt1_reg;
    assign RespValid = resp_valid_reg;
    assign RespId    = resp_id_reg;
    assign RespW     = resp_w_reg;
    assign RespZero  = resp_zero_reg;
    assign RespErr   = resp_err_reg;

endmodule
